cpu_clock_enable: RTL and testbench

- Single-domain clock-enable generator on the 7.00 MHz system clock.
- Derives the free-running 3.5 MHz and 1.75 MHz phase enables.
- Derives the Z80 CPU rising- and falling-edge enables, with ULA memory/IO contention stretching.
- Sits between the clock block and the CPU/ULA/AY instances. All downstream logic runs on clock70 and uses these enables; no derived clocks.

---
 rtl/zx_clock_pkg.sv | 13 +
 rtl/phase_divider.sv | 30 +++
 rtl/cpu_clock_enable.sv | 99 +++++++++
 tb/tb_cpu_clock_enable.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/zx_clock_pkg.sv
// Shared types and constants for the ZX clock-enable blocks.
package zx_clock_pkg;

  typedef enum logic {
    LOW  = 1'b0,
    HIGH = 1'b1
  } cpu_phase_t;

  localparam int unsigned DIV_W        = 2;
  localparam int unsigned MAX_HOLD_DEF = 6;
  localparam int unsigned HOLD_W_DEF   = 3;

endpackage

// File: rtl/phase_divider.sv
// Free-running /2 and /4 phase enables derived from the 7 MHz clock.
module phase_divider
  import zx_clock_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_pe35,
  output logic o_ne35,
  output logic o_pe175
);

  logic [DIV_W-1:0] r_div;
  logic             r_run;

  // run gates the decode so every enable stays low until the first edge after reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div <= '0;
      r_run <= 1'b0;
    end else begin
      r_div <= r_div + DIV_W'(1);
      r_run <= 1'b1;
    end
  end

  assign o_pe35  = r_run & r_div[0];
  assign o_ne35  = r_run & ~r_div[0];
  assign o_pe175 = r_run & (r_div == DIV_W'(1));

endmodule

// File: rtl/cpu_clock_enable.sv
// Z80 clock-enable generator with ULA contention stretching.
// Contention logic is built only when CPU_CONTENTION_EN is defined.
module cpu_clock_enable
  import zx_clock_pkg::*;
#(
  parameter int unsigned MAX_HOLD = MAX_HOLD_DEF,
  parameter int unsigned HOLD_W   = HOLD_W_DEF
) (
  input  logic clock70,
  input  logic reset,
  input  logic contend,
  output logic pe35,
  output logic ne35,
  output logic pe175,
  output logic cpuPe,
  output logic cpuNe,
  output logic holding,
  output logic timeout
);

  phase_divider u_phase_divider (
    .i_clk   (clock70),
    .i_rst_n (reset),
    .o_pe35  (pe35),
    .o_ne35  (ne35),
    .o_pe175 (pe175)
  );

`ifdef CPU_CONTENTION_EN

  cpu_phase_t        r_state;
  cpu_phase_t        w_state_nxt;
  logic [HOLD_W-1:0] r_hold;
  logic [HOLD_W-1:0] w_hold_nxt;
  logic              w_at_max;

  assign w_at_max = (r_hold == HOLD_W'(MAX_HOLD));

  always_ff @(posedge clock70 or negedge reset) begin
    if (!reset) begin
      r_state <= LOW;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  // Transitions only on phase enables, so a stall spans whole 3.5 MHz periods
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    case (r_state)
      LOW: begin
        if (pe35) w_state_nxt = HIGH;
      end
      HIGH: begin
        if (ne35) begin
          if (contend && !w_at_max) begin
            w_hold_nxt = r_hold + HOLD_W'(1);
          end else begin
            w_state_nxt = LOW;
            w_hold_nxt  = '0;
          end
        end
      end
      default: begin
        w_state_nxt = LOW;
        w_hold_nxt  = '0;
      end
    endcase
  end

  always_comb begin
    cpuPe   = 1'b0;
    cpuNe   = 1'b0;
    timeout = 1'b0;
    holding = (r_state == HIGH) && (r_hold != '0);
    if (r_state == LOW) begin
      cpuPe = pe35;
    end else if (ne35) begin
      cpuNe   = !contend || w_at_max;
      timeout = contend && w_at_max;
    end
  end

`else

  logic w_unused;

  assign cpuPe    = pe35;
  assign cpuNe    = ne35;
  assign holding  = 1'b0;
  assign timeout  = 1'b0;
  assign w_unused = ^{contend, 1'(MAX_HOLD), 1'(HOLD_W)};

`endif

endmodule

// File: tb/tb_cpu_clock_enable.sv
// Directed bench for cpu_clock_enable; expectations follow the CPU_CONTENTION_EN setting.
module tb_cpu_clock_enable;
  import zx_clock_pkg::*;

`ifdef CPU_CONTENTION_EN
  localparam bit CONT_EN = 1'b1;
`else
  localparam bit CONT_EN = 1'b0;
`endif

  logic clock70 = 1'b0;
  logic reset   = 1'b0;
  logic contend = 1'b0;
  logic pe35, ne35, pe175, cpuPe, cpuNe, holding, timeout;

  int total = 0;
  int bad   = 0;

  cpu_clock_enable #(.MAX_HOLD(6), .HOLD_W(3)) dut (
    .clock70 (clock70),
    .reset   (reset),
    .contend (contend),
    .pe35    (pe35),
    .ne35    (ne35),
    .pe175   (pe175),
    .cpuPe   (cpuPe),
    .cpuNe   (cpuNe),
    .holding (holding),
    .timeout (timeout)
  );

  always #5 clock70 = ~clock70;

  // Advance one clock70 cycle, then drive contend for that cycle
  task automatic tick(input logic c);
    @(posedge clock70);
    #1;
    contend = c;
    #1;
  endtask

  // Reset, then release on a falling edge so the next rising edge is cycle 1
  task automatic do_reset();
    reset   = 1'b0;
    contend = 1'b0;
    @(negedge clock70);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset   = 1'b0;
    contend = 1'b1;
    #3;
    total++;
    if ({pe35, ne35, pe175, cpuPe, cpuNe, holding, timeout} !== 7'b0) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=0000000",
               {pe35, ne35, pe175, cpuPe, cpuNe, holding, timeout});
    end
    @(posedge clock70);
    #1;
    total++;
    if ({pe35, ne35, pe175, cpuPe, cpuNe, holding, timeout} !== 7'b0) begin
      bad++;
      $display("FAIL reset_held_edge got=%b want=0000000",
               {pe35, ne35, pe175, cpuPe, cpuNe, holding, timeout});
    end
  endtask

  task automatic test_free_run();
    logic ep, en, e175;
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      tick(1'b0);
      ep   = (k % 2) == 1;
      en   = (k % 2) == 0;
      e175 = (k % 4) == 1;
      total++;
      if ({pe35, ne35, pe175} !== {ep, en, e175}) begin
        bad++;
        $display("FAIL free_phase cyc=%0d got=%b want=%b", k, {pe35, ne35, pe175}, {ep, en, e175});
      end
      total++;
      if ({cpuPe, cpuNe, holding, timeout} !== {ep, en, 2'b00}) begin
        bad++;
        $display("FAIL free_cpu cyc=%0d got=%b want=%b", k, {cpuPe, cpuNe, holding, timeout}, {ep, en, 2'b00});
      end
    end
  endtask

  task automatic test_stall();
    logic ep, en, eh;
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      tick((k >= 2 && k <= 7) ? 1'b1 : 1'b0);
      if (CONT_EN) begin
        ep = (k == 1) || (k == 9);
        en = (k == 8) || (k == 10);
        eh = (k >= 3) && (k <= 8);
      end else begin
        ep = (k % 2) == 1;
        en = (k % 2) == 0;
        eh = 1'b0;
      end
      total++;
      if ({cpuPe, cpuNe, holding, timeout} !== {ep, en, eh, 1'b0}) begin
        bad++;
        $display("FAIL stall cyc=%0d got=%b want=%b", k, {cpuPe, cpuNe, holding, timeout}, {ep, en, eh, 1'b0});
      end
    end
  endtask

  task automatic test_timeout();
    logic ep, en, eh, et;
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      tick((k >= 2 && k <= 14) ? 1'b1 : 1'b0);
      if (CONT_EN) begin
        ep = (k == 1) || (k == 15);
        en = (k == 14) || (k == 16);
        eh = (k >= 3) && (k <= 14);
        et = (k == 14);
      end else begin
        ep = (k % 2) == 1;
        en = (k % 2) == 0;
        eh = 1'b0;
        et = 1'b0;
      end
      total++;
      if ({cpuPe, cpuNe, holding, timeout} !== {ep, en, eh, et}) begin
        bad++;
        $display("FAIL timeout cyc=%0d got=%b want=%b", k, {cpuPe, cpuNe, holding, timeout}, {ep, en, eh, et});
      end
    end
  endtask

  task automatic test_pe_pulse();
    logic ep, en;
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      tick((k % 2) == 1);
      ep = (k % 2) == 1;
      en = (k % 2) == 0;
      total++;
      if ({cpuPe, cpuNe, holding, timeout} !== {ep, en, 2'b00}) begin
        bad++;
        $display("FAIL pe_pulse cyc=%0d got=%b want=%b", k, {cpuPe, cpuNe, holding, timeout}, {ep, en, 2'b00});
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    for (int k = 1; k <= 7; k++) tick(k >= 2);
    total++;
    if (holding !== CONT_EN) begin
      bad++;
      $display("FAIL mid_hold_holding got=%b want=%b", holding, CONT_EN);
    end
    reset = 1'b0;
    #1;
    total++;
    if ({pe35, ne35, pe175, cpuPe, cpuNe, holding, timeout} !== 7'b0) begin
      bad++;
      $display("FAIL mid_hold_reset got=%b want=0000000",
               {pe35, ne35, pe175, cpuPe, cpuNe, holding, timeout});
    end
    @(negedge clock70);
    reset = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick(1'b0);
      total++;
      if ({cpuPe, cpuNe, holding, timeout} !== {(k % 2) == 1, (k % 2) == 0, 2'b00}) begin
        bad++;
        $display("FAIL after_mid_hold cyc=%0d got=%b want=%b", k,
                 {cpuPe, cpuNe, holding, timeout}, {(k % 2) == 1, (k % 2) == 0, 2'b00});
      end
    end
  endtask

  task automatic test_no_contention();
    logic ep, en;
    do_reset();
    for (int k = 1; k <= 32; k++) begin
      tick(1'b1);
      ep = (k % 2) == 1;
      en = (k % 2) == 0;
      total++;
      if ({cpuPe, cpuNe, holding, timeout} !== {ep, en, 2'b00}) begin
        bad++;
        $display("FAIL no_contention cyc=%0d got=%b want=%b", k, {cpuPe, cpuNe, holding, timeout}, {ep, en, 2'b00});
      end
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_stall();
    test_timeout();
    test_pe_pulse();
    test_reset_mid_hold();
`ifndef CPU_CONTENTION_EN
    test_no_contention();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
